// File: rtl/conv_fifo_pkg.sv
// Shared status encodings and pointer arithmetic for the convolution stream FIFO.
package conv_fifo_pkg;

  localparam logic [1:0] STAT_EMPTY = 2'b01;
  localparam logic [1:0] STAT_FULL  = 2'b10;
  localparam logic [1:0] STAT_MID   = 2'b00;

  // Occupancy from wrap-bit pointers; result is masked to ptr_w bits so the
  // modulo-2^ptr_w difference is correct whatever width the caller uses.
  function automatic logic [31:0] ptr_count(input logic [31:0] wr,
                                            input logic [31:0] rd,
                                            input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (wr - rd) & mask;
  endfunction

endpackage

// File: rtl/conv_fifo_ram.sv
// Storage array for the stream FIFO: one write port, one registered read port.
// The read register is cleared by reset; the array itself is never cleared.
module conv_fifo_ram
  import conv_fifo_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: unreset storage.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: holds the last popped word until the next accepted read.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_stream_fifo.sv
// Synchronous stream FIFO between the convolution datapath and the
// accumulator/pooling stage. Pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter.
// Optional sticky error flags are built only when CONV_FIFO_ERR_EN is defined.
module conv_stream_fifo
  import conv_fifo_pkg::*;
#(
  parameter int DATA_W   = 20,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [1:0]               status,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic            full, empty, wr_ok, rd_ok;

  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign count        = CNT_W'(ptr_count(32'(wr_ptr), 32'(rd_ptr), CNT_W));
  assign status       = full ? STAT_FULL : (empty ? STAT_EMPTY : STAT_MID);
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));

  // Pointer advance and read-valid strobe; reset overrides any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      rd_valid <= rd_ok;
    end
  end

  conv_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok && !reset),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (rd_ok && !reset),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

`ifdef CONV_FIFO_ERR_EN
  // Sticky error flags; a new error in the same cycle beats err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow <= 1'b1;
      else if (err_clr)   overflow <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (err_clr)   underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_conv_stream_fifo.sv
// Directed bench for conv_stream_fifo at DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
module tb_conv_stream_fifo;

  localparam int DATA_W = 20;
  localparam int DEPTH  = 4;
`ifdef CONV_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, wr_en, rd_en, err_clr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic              rd_valid, almost_full, almost_empty, overflow, underflow;
  logic [1:0]        status;
  logic [2:0]        count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_stream_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .status(status),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_status", 32'(status), 32'h1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);

    // Fill to full, then one dropped write.
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = 20'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af", 32'(almost_full), (i >= 3) ? 1 : 0);
      chk("fill_ae", 32'(almost_empty), (i <= 1) ? 1 : 0);
      chk("fill_status", 32'(status), (i == 4) ? 32'h2 : 32'h0);
    end
    wr_data = 20'hFFFFF;
    tick();
    wr_en = 1'b0;
    chk("drop_count", 32'(count), 4);
    chk("drop_ovf", 32'(overflow), 32'(ERR));
    tick();
    chk("ovf_held", 32'(overflow), 32'(ERR));
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // Drain in order, then a rejected read.
    for (int i = 1; i <= 4; i++) begin
      rd_en = 1'b1;
      tick();
      chk("pop_data", 32'(rd_data), 32'(i));
      chk("pop_valid", 32'(rd_valid), 1);
      chk("pop_count", 32'(count), 32'(4 - i));
    end
    chk("pop_status", 32'(status), 32'h1);
    tick();
    rd_en = 1'b0;
    chk("xrd_valid", 32'(rd_valid), 0);
    chk("xrd_data", 32'(rd_data), 4);
    chk("xrd_udf", 32'(underflow), 32'(ERR));
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("udf_clr", 32'(underflow), 0);

    // Simultaneous read/write at mid, full and empty occupancy.
    wr_en = 1'b1; wr_data = 20'h10; tick();
    wr_data = 20'h11; tick();
    rd_en = 1'b1; wr_data = 20'h12; tick();
    chk("mid_data0", 32'(rd_data), 32'h10);
    chk("mid_count0", 32'(count), 2);
    wr_data = 20'h13; tick();
    chk("mid_data1", 32'(rd_data), 32'h11);
    chk("mid_count1", 32'(count), 2);
    rd_en = 1'b0;
    wr_data = 20'h14; tick();
    wr_data = 20'h15; tick();
    chk("full_count", 32'(count), 4);
    rd_en = 1'b1; wr_data = 20'hAAAAA; tick();
    wr_en = 1'b0;
    chk("fullrw_data", 32'(rd_data), 32'h12);
    chk("fullrw_count", 32'(count), 3);
    tick(); chk("drain0", 32'(rd_data), 32'h13);
    tick(); chk("drain1", 32'(rd_data), 32'h14);
    tick(); chk("drain2", 32'(rd_data), 32'h15);
    chk("drain_count", 32'(count), 0);
    wr_en = 1'b1; wr_data = 20'h20; tick();
    wr_en = 1'b0;
    chk("emptyrw_count", 32'(count), 1);
    chk("emptyrw_valid", 32'(rd_valid), 0);
    chk("emptyrw_data", 32'(rd_data), 32'h15);
    tick(); rd_en = 1'b0;
    chk("emptyrw_pop", 32'(rd_data), 32'h20);
    chk("emptyrw_cnt0", 32'(count), 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Streaming across pointer wrap.
    wr_en = 1'b1; wr_data = 20'h100; tick();
    rd_en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      wr_data = 20'(32'h101 + k);
      tick();
      chk("wrap_data", 32'(rd_data), 32'h100 + k);
      chk("wrap_count", 32'(count), 1);
      chk("wrap_status", 32'(status), 32'h0);
    end
    wr_en = 1'b0; tick(); rd_en = 1'b0;
    chk("wrap_last", 32'(rd_data), 32'h10B);
    chk("wrap_end_cnt", 32'(count), 0);

    // Reset in the middle of a pop.
    wr_en = 1'b1;
    wr_data = 20'h31; tick();
    wr_data = 20'h32; tick();
    wr_data = 20'h33; tick();
    wr_en = 1'b0;
    chk("pre_rst_cnt", 32'(count), 3);
    rd_en = 1'b1; reset = 1'b1; tick();
    reset = 1'b0; rd_en = 1'b0;
    chk("mrst_count", 32'(count), 0);
    chk("mrst_valid", 32'(rd_valid), 0);
    chk("mrst_status", 32'(status), 32'h1);
    chk("mrst_data", 32'(rd_data), 0);

    // Set beats clear, then underflow after reset.
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 20'(32'h40 + i); tick();
    end
    chk("ovf_set", 32'(overflow), 32'(ERR));
    err_clr = 1'b1; tick();
    chk("ovf_set_wins", 32'(overflow), 32'(ERR));
    wr_en = 1'b0; tick(); err_clr = 1'b0;
    chk("ovf_clr2", 32'(overflow), 0);
    reset = 1'b1; tick(); reset = 1'b0;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("udf_set", 32'(underflow), 32'(ERR));
    chk("udf_valid", 32'(rd_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
